// File: rtl/piso_stream_if.sv
// Handshake bundle for piso_stream: parallel load side plus serial output side.
// The slave modport is the serialiser's view; master is the producer/consumer view.
interface piso_stream_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             load_valid;
    logic             load_ready;
    logic             out_ready;
    logic             q;
    logic             q_valid;
    logic             q_first;
    logic             q_last;
    logic             busy;

    modport master (
        output din, load_valid, out_ready,
        input  load_ready, q, q_valid, q_first, q_last, busy
    );

    modport slave (
        input  din, load_valid, out_ready,
        output load_ready, q, q_valid, q_first, q_last, busy
    );
endinterface

// File: rtl/piso_stream.sv
// Parallel-in serial-out streamer: one-word holding register feeding a shifter,
// so a following frame can start on the edge that retires the last bit.
module piso_stream #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    piso_stream_if.slave bus
);
    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_hold;
    logic             r_hold_full;
    logic [WIDTH-1:0] r_shift;
    logic [CNT_W-1:0] r_cnt;

    logic             w_load;
    logic             w_xfer;
    logic             w_last;
    logic [WIDTH-1:0] w_shift_next;

    assign w_load       = bus.load_valid && !r_hold_full;
    assign w_xfer       = (r_state == SHIFT) && bus.out_ready;
    assign w_last       = (r_cnt == LAST_CNT);
    assign w_shift_next = LSB_FIRST ? (r_shift >> 1) : (r_shift << 1);

    // NOTE: r_hold is data only; r_hold_full qualifies it, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_hold <= bus.din;
        end
    end

    // A load needs hold_full=0 and a drain needs hold_full=1, so the two
    // updates of r_hold_full below can never collide on one edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_hold_full <= 1'b0;
            r_shift     <= '0;
            r_cnt       <= '0;
        end else begin
            if (w_load) begin
                r_hold_full <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (r_hold_full) begin
                        r_shift     <= r_hold;
                        r_hold_full <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_cnt <= '0;
                            if (r_hold_full) begin
                                r_shift     <= r_hold;
                                r_hold_full <= 1'b0;
                            end else begin
                                r_shift <= w_shift_next;
                                r_state <= IDLE;
                            end
                        end else begin
                            r_shift <= w_shift_next;
                            r_cnt   <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: every output decodes registered state only; no input reaches an output.
    assign bus.load_ready = !r_hold_full;
    assign bus.q_valid    = (r_state == SHIFT);
    assign bus.q          = bus.q_valid && (LSB_FIRST ? r_shift[0] : r_shift[WIDTH-1]);
    assign bus.q_first    = bus.q_valid && (r_cnt == '0);
    assign bus.q_last     = bus.q_valid && w_last;
    assign bus.busy       = bus.q_valid || r_hold_full;
endmodule

// File: tb/tb_piso_stream.sv
// Scoreboard bench for piso_stream: an MSB-first and an LSB-first instance share
// one stimulus stream; accepted words are expanded into expected bit queues.
module tb_piso_stream;
    localparam int W = 8;

    typedef struct packed {
        logic q;
        logic first;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   rand_or = 1'b0;
    exp_t exp0[$];
    exp_t exp1[$];

    piso_stream_if #(.WIDTH(W)) b0 ();
    piso_stream_if #(.WIDTH(W)) b1 ();

    piso_stream #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (.clk(clk), .rst(rst), .bus(b0));
    piso_stream #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (.clk(clk), .rst(rst), .bus(b1));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_load(input logic [W-1:0] d, input logic lv);
        b0.din = d;  b1.din = d;
        b0.load_valid = lv;  b1.load_valid = lv;
    endtask

    task automatic set_or(input logic v);
        b0.out_ready = v;
        b1.out_ready = v;
    endtask

    // Reference model: an accepted word becomes WIDTH bits in the chosen order.
    always @(negedge clk) begin
        if (!rst && b0.load_valid && b0.load_ready) begin
            for (int i = 0; i < W; i++) begin
                exp0.push_back('{q: b0.din[W-1-i], first: (i == 0), last: (i == W-1)});
                exp1.push_back('{q: b0.din[i],     first: (i == 0), last: (i == W-1)});
            end
        end
    end

    // Monitors: compare the presented bit against the queue head; pop on transfer.
    always @(negedge clk) begin
        if (b0.q_valid) begin
            if (exp0.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL msb_unexpected_bit: got q_valid=1, expected no bit (t=%0t)", $time);
            end else begin
                check("msb_q", b0.q, exp0[0].q);
                check("msb_first", b0.q_first, exp0[0].first);
                check("msb_last", b0.q_last, exp0[0].last);
                if (b0.out_ready && !rst) void'(exp0.pop_front());
            end
        end else begin
            check("msb_idle_outputs", {b0.q, b0.q_first, b0.q_last}, 0);
        end
    end

    always @(negedge clk) begin
        if (b1.q_valid) begin
            if (exp1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL lsb_unexpected_bit: got q_valid=1, expected no bit (t=%0t)", $time);
            end else begin
                check("lsb_q", b1.q, exp1[0].q);
                check("lsb_first", b1.q_first, exp1[0].first);
                check("lsb_last", b1.q_last, exp1[0].last);
                if (b1.out_ready && !rst) void'(exp1.pop_front());
            end
        end else begin
            check("lsb_idle_outputs", {b1.q, b1.q_first, b1.q_last}, 0);
        end
    end

    always @(posedge clk) begin
        if (rand_or) begin
            #1;
            set_or($urandom_range(0, 3) != 0);
        end
    end

    task automatic load_word(input logic [W-1:0] w);
        bit done = 1'b0;
        set_load(w, 1'b1);
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (b0.load_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        set_load(w, 1'b0);
        if (!done) begin
            n_tests++; n_fail++;
            $display("FAIL load_timeout: got no acceptance, expected load of 0x%0h", w);
            @(posedge clk);
            #1;
        end
    endtask

    // Counts one contiguous run of q_valid cycles on the MSB instance.
    task automatic count_valid(output int n);
        int k = 0;
        n = 0;
        @(negedge clk);
        while (!b0.q_valid && k < 100) begin
            @(negedge clk);
            k++;
        end
        while (b0.q_valid && n < 100) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((b0.busy || b1.busy) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        @(posedge clk);
        #1;
        check("drain_busy", {b0.busy, b1.busy}, 0);
        check("drain_queues_empty", exp0.size() + exp1.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        set_load('0, 1'b0);
        set_or(1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_load_ready", b0.load_ready, 1);
        check("reset_q_valid", b0.q_valid, 0);
        check("reset_busy", b0.busy, 0);

        // 0x01: first bit one cycle after acceptance, 8 valid cycles.
        load_word(8'h01);
        check("accept_q_valid", b0.q_valid, 0);
        check("accept_busy", b0.busy, 1);
        check("accept_load_ready", b0.load_ready, 0);
        @(posedge clk);
        #1;
        check("first_bit_valid", b0.q_valid, 1);
        check("first_bit_first", b0.q_first, 1);
        check("first_bit_load_ready", b0.load_ready, 1);
        count_valid(n);
        check("frame_len_0x01", n, 8);

        // Back-to-back frames 0xF0 then 0x0F with no gap.
        fork
            count_valid(n);
            begin
                load_word(8'hF0);
                load_word(8'h0F);
            end
        join
        check("b2b_contiguous_len", n, 16);
        wait_idle();

        // Stall while bit 3 of 0xA5 is presented.
        fork
            count_valid(n);
            begin
                load_word(8'hA5);
                @(posedge clk);
                #1;
                check("stall_frame_first", b0.q_first, 1);
                repeat (3) begin @(posedge clk); #1; end
                check("stall_bit3", b0.q, 0);
                set_or(1'b0);
                repeat (3) begin @(posedge clk); #1; end
                check("stall_hold_q", b0.q, 0);
                check("stall_hold_valid", b0.q_valid, 1);
                set_or(1'b1);
            end
        join
        check("stall_frame_len", n, 11);
        wait_idle();

        // Third word must wait while one shifts and one is held.
        load_word(8'h3C);
        load_word(8'hC7);
        check("third_blocked_ready", b0.load_ready, 0);
        check("third_blocked_busy", b0.busy, 1);
        load_word(8'h81);
        wait_idle();

        // Reset at bit 4 with a word held.
        load_word(8'h5A);
        load_word(8'hC3);
        repeat (3) begin @(posedge clk); #1; end
        check("pre_reset_valid", b0.q_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp0.delete();
        exp1.delete();
        check("post_reset_valid", b0.q_valid, 0);
        check("post_reset_busy", b0.busy, 0);
        check("post_reset_ready", b0.load_ready, 1);
        @(posedge clk);
        #1;
        check("post_reset_no_held", b0.q_valid, 0);
        load_word(8'h96);
        wait_idle();

        // Random words with random gaps and random back-pressure.
        rand_or = 1'b1;
        for (int i = 0; i < 30; i++) begin
            load_word(W'($urandom));
            repeat ($urandom_range(0, 6)) begin @(posedge clk); #1; end
        end
        rand_or = 1'b0;
        @(posedge clk);
        #2;
        set_or(1'b1);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/piso_stream.md
PISO_STREAM -- requirements
Module: piso_stream

Interface
REQ-001 Parameter: WIDTH, 8, parallel word width in bits; legal range 2..32.
REQ-002 Parameter: LSB_FIRST, 0, serial bit order; 0 = MSB first, 1 = LSB first.
REQ-003 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset; synchronous and active-high.
REQ-005 Port: din  input  WIDTH  parallel word to serialise.
REQ-006 Port: load_valid  input  1  din is valid and offered for loading.
REQ-007 Port: load_ready  output  1  block can accept a word this cycle.
REQ-008 Port: out_ready  input  1  serial consumer accepts the current bit this cycle.
REQ-009 Port: q  output  1  serial data bit.
REQ-010 Port: q_valid  output  1  q carries a valid bit.
REQ-011 Port: q_first  output  1  q is bit 0 of a frame.
REQ-012 Port: q_last  output  1  q is bit WIDTH-1 of a frame.
REQ-013 Port: busy  output  1  q_valid OR holding register full.

Function
REQ-014 The block SHALL contain a WIDTH-bit holding register with a full flag, a WIDTH-bit shift register, a bit counter of clog2(WIDTH) bits, and a two-state FSM: IDLE and SHIFT.
REQ-015 load_ready SHALL equal NOT hold_full, derived from registered state only, with no combinational path from load_valid or out_ready.
REQ-016 A word SHALL be accepted at a rising edge where load_valid and load_ready are both 1: din is written to the holding register and hold_full is set.
REQ-017 In IDLE with hold_full=1, the next edge SHALL move the holding word into the shifter, clear hold_full, zero the counter and enter SHIFT; the first bit appears one cycle after acceptance.
REQ-018 In SHIFT, q SHALL be shifter[WIDTH-1] when LSB_FIRST=0, or shifter[0] when LSB_FIRST=1; q_valid=1; q_first=(cnt==0); q_last=(cnt==WIDTH-1).
REQ-019 A bit SHALL transfer on an edge where q_valid and out_ready are both 1; the shifter then shifts toward the output end, zero-filled, and cnt increments.
REQ-020 With out_ready=0, the shifter, cnt, q, q_first and q_last SHALL hold unchanged.
REQ-021 On transfer of the last bit: if hold_full=1, the shifter SHALL reload from the holding register on that same edge (cnt=0, hold_full cleared, stay in SHIFT; frames back-to-back with no gap cycle); otherwise the FSM SHALL return to IDLE.
REQ-022 In IDLE, q, q_valid, q_first and q_last SHALL be 0.
REQ-023 Because load_ready is registered, a load and a holding-register drain SHALL never occur on the same edge; a word offered while hold_full=1 SHALL wait with no loss or overwrite.
REQ-024 load_valid asserted while load_ready=0 SHALL have no effect.

Reset
REQ-025 With rst=1 at an edge, the block SHALL enter IDLE with hold_full=0, cnt=0 and shifter=0; q, q_valid, q_first, q_last and busy SHALL be 0 and load_ready SHALL be 1 from the following cycle.
REQ-026 Reset during a frame SHALL discard both the in-flight word and the held word; no further bits of either are emitted.
REQ-027 rst SHALL take priority over a simultaneous load or transfer at the same edge.

Verification
REQ-028 WIDTH=8, LSB_FIRST=0, out_ready=1, load 0x01 -> q = 0,0,0,0,0,0,0,1 over 8 consecutive q_valid cycles; q_first on the 1st cycle, q_last on the 8th.
REQ-029 WIDTH=8, LSB_FIRST=1, load 0x01 -> q = 1,0,0,0,0,0,0,0.
REQ-030 Load 0xF0, then load 0x0F as soon as load_ready returns -> 16 contiguous q_valid cycles, q = 1111000000001111, q_first on cycles 1 and 9, no idle gap.
REQ-031 Drop out_ready for 3 cycles while bit 3 of 0xA5 is presented -> q stays stable and the frame completes 11 cycles after the first bit with the correct sequence 10100101.
REQ-032 With one word shifting and a second word held, offer a third -> load_ready=0 and the third word is accepted only after the held word moves to the shifter; all three words are emitted in order.
REQ-033 Assert rst at bit 4 of a frame with a word held -> the next cycle shows q_valid=0, busy=0 and load_ready=1; a new word then serialises correctly.
